// File: rtl/gmii_rx_ctrl.sv
// GMII receive sequencing controller: applies speed/mode/enable changes
// only at idle inter-frame gaps and keeps saturating receive statistics.
module gmii_rx_ctrl #(
    parameter int IDLE_TICKS    = 12,
    parameter int DRAIN_TIMEOUT = 65535,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           cfg_speed_req,
    input  logic                 cfg_mii_mode_req,
    input  logic                 cfg_rx_enable_req,
    input  logic                 gmii_rx_dv,
    input  logic                 start_packet,
    input  logic                 rx_tvalid,
    input  logic                 rx_tlast,
    input  logic                 error_bad_frame,
    input  logic                 error_bad_fcs,
    input  logic                 stat_clear,
    output logic                 clk_enable,
    output logic                 mii_select,
    output logic                 cfg_rx_enable,
    output logic [1:0]           speed_active,
    output logic                 update_pending,
    output logic                 cfg_timeout,
    output logic [CNT_WIDTH-1:0] stat_frames,
    output logic [CNT_WIDTH-1:0] stat_bad_frame,
    output logic [CNT_WIDTH-1:0] stat_bad_fcs
);

    localparam logic [1:0] S_ACTIVE = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_QUIET  = 2'd2;
    localparam logic [1:0] S_APPLY  = 2'd3;

    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int IW = $clog2(IDLE_TICKS + 1);

    logic [1:0]    state;
    logic [TW-1:0] tmo;
    logic [IW-1:0] idle;
    logic [6:0]    presc;
    logic [6:0]    div_n;
    logic          frame_open;
    logic          app_mii;
    logic [1:0]    req_speed;
    logic          pend;
    logic [1:0]    nxt_speed;
    logic          nxt_mii;

    // Speed code 11 is folded into 1G so it never shows up as a change.
    assign req_speed = (cfg_speed_req == 2'b11) ? 2'b10 : cfg_speed_req;
    assign pend = {req_speed, cfg_mii_mode_req, cfg_rx_enable_req}
               != {speed_active, app_mii, cfg_rx_enable};

    always_comb begin
        div_n = 7'd1;
        if (speed_active != 2'b10 && !app_mii)
            div_n = (speed_active == 2'b01) ? 7'd10 : 7'd100;
    end

    always_comb begin
        nxt_speed = speed_active;
        nxt_mii   = app_mii;
        if (state == S_APPLY) begin
            nxt_speed = req_speed;
            nxt_mii   = cfg_mii_mode_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_ACTIVE;
            tmo            <= '0;
            idle           <= '0;
            presc          <= '0;
            frame_open     <= 1'b0;
            app_mii        <= 1'b0;
            speed_active   <= 2'b10;
            cfg_rx_enable  <= 1'b0;
            clk_enable     <= 1'b1;
            mii_select     <= 1'b0;
            update_pending <= 1'b0;
            cfg_timeout    <= 1'b0;
        end else begin
            update_pending <= pend;
            cfg_timeout    <= 1'b0;
            clk_enable     <= (presc == 7'd0);
            mii_select     <= nxt_mii & (nxt_speed != 2'b10);

            if (state == S_APPLY || presc >= div_n - 7'd1)
                presc <= '0;
            else
                presc <= presc + 7'd1;

            if (start_packet)
                frame_open <= 1'b1;
            else if (rx_tvalid && rx_tlast)
                frame_open <= 1'b0;

            case (state)
                S_ACTIVE: begin
                    if (pend) begin
                        state <= S_DRAIN;
                        tmo   <= TW'(1);
                    end
                end
                S_DRAIN, S_QUIET: begin
                    if (!pend) begin
                        state <= S_ACTIVE;
                    end else if (tmo >= TW'(DRAIN_TIMEOUT)) begin
                        state       <= S_APPLY;
                        cfg_timeout <= 1'b1;
                    end else begin
                        tmo <= tmo + TW'(1);
                        if (state == S_DRAIN) begin
                            if (!frame_open && !gmii_rx_dv) begin
                                state <= S_QUIET;
                                idle  <= '0;
                            end
                        end else if (gmii_rx_dv || start_packet) begin
                            state <= S_DRAIN;
                        end else if (idle == IW'(IDLE_TICKS)) begin
                            state <= S_APPLY;
                        end else if (clk_enable) begin
                            idle <= idle + IW'(1);
                        end
                    end
                end
                default: begin
                    state         <= S_ACTIVE;
                    speed_active  <= req_speed;
                    app_mii       <= cfg_mii_mode_req;
                    cfg_rx_enable <= cfg_rx_enable_req;
                end
            endcase
        end
    end

    // Clear beats a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            stat_frames    <= '0;
            stat_bad_frame <= '0;
            stat_bad_fcs   <= '0;
        end else begin
            if (start_packet && stat_frames != '1)
                stat_frames <= stat_frames + 1'b1;
            if (error_bad_frame && stat_bad_frame != '1)
                stat_bad_frame <= stat_bad_frame + 1'b1;
            if (error_bad_fcs && stat_bad_fcs != '1)
                stat_bad_fcs <= stat_bad_fcs + 1'b1;
        end
    end

endmodule

// File: tb/tb_gmii_rx_ctrl.sv
// Scoreboard bench for gmii_rx_ctrl: directed scenarios push expected
// values into a queue that a negedge monitor pops and compares.
module tb_gmii_rx_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cfg_speed_req = 2'b10;
    logic          cfg_mii_mode_req = 1'b0;
    logic          cfg_rx_enable_req = 1'b0;
    logic          gmii_rx_dv = 1'b0;
    logic          start_packet = 1'b0;
    logic          rx_tvalid = 1'b0;
    logic          rx_tlast = 1'b0;
    logic          error_bad_frame = 1'b0;
    logic          error_bad_fcs = 1'b0;
    logic          stat_clear = 1'b0;
    logic          clk_enable;
    logic          mii_select;
    logic          cfg_rx_enable;
    logic [1:0]    speed_active;
    logic          update_pending;
    logic          cfg_timeout;
    logic [CW-1:0] stat_frames;
    logic [CW-1:0] stat_bad_frame;
    logic [CW-1:0] stat_bad_fcs;

    gmii_rx_ctrl #(
        .IDLE_TICKS(12),
        .DRAIN_TIMEOUT(100),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_speed_req(cfg_speed_req),
        .cfg_mii_mode_req(cfg_mii_mode_req),
        .cfg_rx_enable_req(cfg_rx_enable_req),
        .gmii_rx_dv(gmii_rx_dv),
        .start_packet(start_packet),
        .rx_tvalid(rx_tvalid),
        .rx_tlast(rx_tlast),
        .error_bad_frame(error_bad_frame),
        .error_bad_fcs(error_bad_fcs),
        .stat_clear(stat_clear),
        .clk_enable(clk_enable),
        .mii_select(mii_select),
        .cfg_rx_enable(cfg_rx_enable),
        .speed_active(speed_active),
        .update_pending(update_pending),
        .cfg_timeout(cfg_timeout),
        .stat_frames(stat_frames),
        .stat_bad_frame(stat_bad_frame),
        .stat_bad_fcs(stat_bad_fcs)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sig;
        bit          meas;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [31:0] get_sig(int id);
        case (id)
            0: return {31'd0, clk_enable};
            1: return {31'd0, mii_select};
            2: return {31'd0, cfg_rx_enable};
            3: return {30'd0, speed_active};
            4: return {31'd0, update_pending};
            5: return {31'd0, cfg_timeout};
            6: return {28'd0, stat_frames};
            7: return {28'd0, stat_bad_frame};
            8: return {28'd0, stat_bad_fcs};
            default: return 32'hdead;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        chk_t        c;
        logic [31:0] a;
        while (q.size() > 0) begin
            c = q.pop_front();
            a = c.meas ? c.act : get_sig(c.sig);
            n_chk++;
            if (a !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", c.name, a, c.exp);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_sig(string nm, int id, logic [31:0] e);
        chk_t c;
        c.name = nm; c.sig = id; c.meas = 1'b0; c.act = '0; c.exp = e;
        q.push_back(c);
    endtask

    task automatic exp_meas(string nm, logic [31:0] a, logic [31:0] e);
        chk_t c;
        c.name = nm; c.sig = -1; c.meas = 1'b1; c.act = a; c.exp = e;
        q.push_back(c);
    endtask

    task automatic wait_for(string nm, int id, logic [31:0] v, int maxc);
        int cyc = 0;
        while (get_sig(id) !== v && cyc < maxc) begin
            tick(1);
            cyc++;
        end
        if (get_sig(id) !== v)
            exp_meas({nm, "_wait"}, get_sig(id), v);
    endtask

    task automatic set_req(logic [1:0] s, logic m, logic e);
        cfg_speed_req     = s;
        cfg_mii_mode_req  = m;
        cfg_rx_enable_req = e;
    endtask

    initial begin
        int first, first2, cnt, cnt2, viol, last, spd;

        // Reset state
        tick(3);
        exp_sig("rst_clk_enable", 0, 1);
        exp_sig("rst_mii_select", 1, 0);
        exp_sig("rst_rx_enable", 2, 0);
        exp_sig("rst_speed", 3, 2);
        exp_sig("rst_pending", 4, 0);
        exp_sig("rst_timeout", 5, 0);
        exp_sig("rst_frames", 6, 0);
        rst = 1'b0;
        tick(2);

        // Enable at 1G while idle
        first = -1; cnt = 0; viol = 0;
        for (int c = 0; c < 26; c++) begin
            if (c == 0) set_req(2'b10, 1'b0, 1'b1);
            if (c == 1) exp_sig("en_pending_set", 4, 1);
            if (cfg_rx_enable && first < 0) first = c;
            if (cfg_timeout) cnt++;
            if (c >= 18 && !clk_enable) viol++;
            tick(1);
        end
        exp_meas("en_apply_cycle", first, 16);
        exp_meas("en_no_timeout", cnt, 0);
        exp_meas("en_clk_enable_steady", viol, 0);
        exp_sig("en_pending_clear", 4, 0);
        exp_sig("en_mii_select", 1, 0);

        // Change to 10M native MII while a 64-byte frame is in flight
        first = -1; cnt = 0; viol = 0; cnt2 = 0;
        for (int c = 0; c < 100; c++) begin
            if (c == 0) set_req(2'b00, 1'b1, 1'b1);
            start_packet = (c == 0);
            gmii_rx_dv   = (c < 64);
            rx_tvalid    = (c < 64);
            rx_tlast     = (c == 63);
            if (mii_select && first < 0) first = c;
            if (first < 0 && (!clk_enable || speed_active != 2'b10)) viol++;
            if (cfg_timeout) cnt++;
            if (c >= 80 && clk_enable) cnt2++;
            tick(1);
        end
        start_packet = 1'b0;
        exp_meas("frame_apply_cycle", first, 79);
        exp_meas("frame_outputs_held", viol, 0);
        exp_meas("frame_no_timeout", cnt, 0);
        exp_meas("mii_clk_enable_steady", cnt2, 20);
        exp_sig("mii_speed", 3, 0);

        // 100M byte-replicated: one enable every 10 cycles
        set_req(2'b01, 1'b0, 1'b1);
        wait_for("m100", 3, 1, 60);
        tick(2);
        cnt = 0; viol = 0; last = -1;
        for (int c = 0; c < 100; c++) begin
            if (clk_enable) begin
                if (last >= 0 && c - last != 10) viol++;
                last = c;
                cnt++;
            end
            tick(1);
        end
        exp_meas("m100_pulses", cnt, 10);
        exp_meas("m100_period", viol, 0);
        exp_sig("m100_mii_select", 1, 0);

        // dv stuck high forces the 10M change after the drain timeout
        first = -1; cnt = 0; first2 = -1; cnt2 = 0; spd = -1;
        for (int c = 0; c < 403; c++) begin
            if (c == 0) set_req(2'b00, 1'b0, 1'b1);
            gmii_rx_dv = 1'b1;
            if (cfg_timeout) begin
                if (first < 0) first = c;
                cnt++;
            end
            if (c == 102) spd = int'(speed_active);
            if (c >= 103 && clk_enable) begin
                if (first2 < 0) first2 = c;
                cnt2++;
            end
            tick(1);
        end
        gmii_rx_dv = 1'b0;
        exp_meas("tmo_pulse_cycle", first, 101);
        exp_meas("tmo_pulse_width", cnt, 1);
        exp_meas("tmo_speed_applied", spd, 0);
        exp_meas("m10_first_pulse", first2, 103);
        exp_meas("m10_pulses", cnt2, 3);

        // Back to 1G
        set_req(2'b10, 1'b0, 1'b1);
        wait_for("g1", 3, 2, 300);
        tick(3);

        // dv glitch at idle count 11 restarts the quiet window
        first = -1; cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 0) set_req(2'b10, 1'b0, 1'b0);
            gmii_rx_dv = (c == 13);
            if (!cfg_rx_enable && first < 0) first = c;
            if (cfg_timeout) cnt++;
            tick(1);
        end
        exp_meas("quiet_restart_apply", first, 29);
        exp_meas("quiet_no_timeout", cnt, 0);

        // Request reverted before apply: nothing changes
        cnt = 0; cnt2 = 0;
        for (int c = 0; c < 36; c++) begin
            if (c == 0) set_req(2'b10, 1'b0, 1'b1);
            if (c == 6) set_req(2'b10, 1'b0, 1'b0);
            if (cfg_rx_enable) cnt++;
            if (cfg_timeout) cnt2++;
            tick(1);
        end
        exp_meas("revert_no_apply", cnt, 0);
        exp_meas("revert_no_timeout", cnt2, 0);
        exp_sig("revert_pending", 4, 0);

        // Statistics counters
        stat_clear = 1'b1;
        tick(1);
        stat_clear = 1'b0;
        exp_sig("stat_cleared", 6, 0);
        for (int i = 0; i < 17; i++) begin
            start_packet = 1'b1;
            tick(1);
        end
        start_packet = 1'b0;
        exp_sig("frames_saturate", 6, 15);
        for (int i = 0; i < 3; i++) begin
            error_bad_frame = 1'b1;
            tick(1);
        end
        error_bad_frame = 1'b0;
        exp_sig("bad_frame_count", 7, 3);
        for (int i = 0; i < 5; i++) begin
            error_bad_fcs = 1'b1;
            tick(1);
        end
        exp_sig("bad_fcs_count", 8, 5);
        stat_clear = 1'b1;
        tick(1);
        stat_clear = 1'b0;
        error_bad_fcs = 1'b0;
        exp_sig("clear_beats_fcs", 8, 0);
        exp_sig("clear_bad_frame", 7, 0);
        tick(1);
        exp_sig("clear_frames_hold", 6, 0);

        // Reset while draining
        gmii_rx_dv = 1'b1;
        set_req(2'b01, 1'b0, 1'b1);
        error_bad_frame = 1'b1;
        tick(5);
        error_bad_frame = 1'b0;
        rst = 1'b1;
        tick(1);
        exp_sig("rst_mid_speed", 3, 2);
        exp_sig("rst_mid_rx_enable", 2, 0);
        exp_sig("rst_mid_bad_frame", 7, 0);
        rst = 1'b0;
        gmii_rx_dv = 1'b0;
        set_req(2'b10, 1'b0, 1'b0);
        tick(3);

        n_chk++;
        if (speed_active !== 2'b10) begin
            n_fail++;
            $display("FAIL post_rst_speed: got %0d expected 2", speed_active);
        end
        n_chk++;
        if (cfg_rx_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_rx_enable: got %0d expected 0",
                     cfg_rx_enable);
        end
        n_chk++;
        if (mii_select !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_mii_select: got %0d expected 0",
                     mii_select);
        end
        n_chk++;
        if (clk_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL post_rst_clk_enable: got %0d expected 1",
                     clk_enable);
        end
        n_chk++;
        if (update_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_pending: got %0d expected 0",
                     update_pending);
        end
        n_chk++;
        if (cfg_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_timeout: got %0d expected 0",
                     cfg_timeout);
        end
        n_chk++;
        if (stat_bad_frame !== 4'd0) begin
            n_fail++;
            $display("FAIL post_rst_bad_frame: got %0d expected 0",
                     stat_bad_frame);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
